// File: rtl/hack_mem_pkg.sv
// rtl/hack_mem_pkg.sv - shared defaults, FSM state type and NOP word for the Hack program ROM
package hack_mem_pkg;

  localparam int ADDR_W_DEFAULT = 15;
  localparam int DATA_W_DEFAULT = 16;
  localparam int DEPTH_DEFAULT  = 1024;

  // Word returned for any fetch that cannot reach a resident program word.
  localparam int NOP_WORD = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } rom_state_t;

endpackage

// File: rtl/hack_ram_1r1w.sv
// rtl/hack_ram_1r1w.sv - instruction storage with synchronous write and registered read
module hack_ram_1r1w #(
  parameter int AW    = 10,
  parameter int DW    = 16,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the controller gates every read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hack_prog_rom.sv
// rtl/hack_prog_rom.sv - loadable program ROM holding the CPU in reset until a program is resident
module hack_prog_rom
  import hack_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              loaded,
  output logic              cpu_rst_n,
  output logic              overflow
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W + 1)'(DEPTH);

  rom_state_t        state;
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   prog_len;
  logic              rd_ok;
  logic              beat;
  logic [DATA_W-1:0] ram_q;

  assign load_ready = (state == ST_LOAD) && !load_start;
  assign beat       = load_valid && load_ready;
  assign loaded     = (state == ST_RUN);
  assign cpu_rst_n  = loaded;

  // A restart request wins over everything; otherwise beats fill memory until
  // the loader marks the last word or the array is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      wptr     <= '0;
      prog_len <= '0;
      overflow <= 1'b0;
    end else if (load_start) begin
      state    <= ST_LOAD;
      wptr     <= '0;
      prog_len <= '0;
      overflow <= 1'b0;
    end else if (beat) begin
      wptr <= wptr + 1'b1;
      if (load_last) begin
        prog_len <= wptr + 1'b1;
        state    <= ST_RUN;
      end else if (wptr == LAST_IDX) begin
        prog_len <= FULL_LEN;
        overflow <= 1'b1;
        state    <= ST_RUN;
      end
    end
  end

  // Qualifies the RAM's registered read; a restart in RUN already blanks the fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ok <= 1'b0;
    end else begin
      rd_ok <= (state == ST_RUN) && !load_start && ({1'b0, address} < prog_len);
    end
  end

  assign data = rd_ok ? ram_q : DATA_W'(NOP_WORD);

  hack_ram_1r1w #(
    .AW   (RAM_AW),
    .DW   (DATA_W),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (beat),
    .waddr(wptr[RAM_AW-1:0]),
    .wdata(load_data),
    .raddr(address[RAM_AW-1:0]),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_hack_prog_rom.sv
// tb/tb_hack_prog_rom.sv - randomized self-checking bench for hack_prog_rom against a behavioural model
module tb_hack_prog_rom;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] address = '0;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_last = 1'b0;

  logic [15:0] data_a, data_b;
  logic        ready_a, ready_b, loaded_a, loaded_b, crst_a, crst_b, ovf_a, ovf_b;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  hack_prog_rom dut_a (
    .clk(clk), .rst_n(rst_n), .address(address), .data(data_a),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(ready_a), .loaded(loaded_a),
    .cpu_rst_n(crst_a), .overflow(ovf_a)
  );

  hack_prog_rom #(.ADDR_W(15), .DATA_W(16), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .address(address), .data(data_b),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(ready_b), .loaded(loaded_b),
    .cpu_rst_n(crst_b), .overflow(ovf_b)
  );

  // Behavioural model: one entry per DUT (0 = DEPTH 1024, 1 = DEPTH 4).
  int          depth_of [2] = '{1024, 4};
  bit          m_loading [2];
  bit          m_running [2];
  bit          m_ovf [2];
  int          m_cnt [2];
  int          m_len [2];
  logic [15:0] m_data [2];
  logic [15:0] m_mem [2][1024];

  initial begin
    for (int i = 0; i < 2; i++) m_data[i] = '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_loading[i] = 1'b0; m_running[i] = 1'b0; m_ovf[i] = 1'b0;
        m_cnt[i] = 0; m_len[i] = 0; m_data[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_running[i] && !load_start && int'(address) < m_len[i])
          m_data[i] = m_mem[i][int'(address)];
        else
          m_data[i] = '0;
        if (load_start) begin
          m_loading[i] = 1'b1; m_running[i] = 1'b0;
          m_cnt[i] = 0; m_len[i] = 0; m_ovf[i] = 1'b0;
        end else if (m_loading[i] && load_valid) begin
          m_mem[i][m_cnt[i]] = load_data;
          m_cnt[i]++;
          if (load_last) begin
            m_len[i] = m_cnt[i]; m_loading[i] = 1'b0; m_running[i] = 1'b1;
          end else if (m_cnt[i] == depth_of[i]) begin
            m_len[i] = depth_of[i]; m_ovf[i] = 1'b1;
            m_loading[i] = 1'b0; m_running[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output of both instances against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 2; i++) begin
        logic [15:0] d;
        logic r, l, c, o;
        d = (i == 0) ? data_a : data_b;
        r = (i == 0) ? ready_a : ready_b;
        l = (i == 0) ? loaded_a : loaded_b;
        c = (i == 0) ? crst_a : crst_b;
        o = (i == 0) ? ovf_a : ovf_b;
        chk($sformatf("cyc_data[%0d]", i), 32'(d), 32'(m_data[i]));
        chk($sformatf("cyc_ready[%0d]", i), 32'(r), 32'(m_loading[i] && !load_start));
        chk($sformatf("cyc_loaded[%0d]", i), 32'(l), 32'(m_running[i]));
        chk($sformatf("cyc_cpu_rst_n[%0d]", i), 32'(c), 32'(m_running[i]));
        chk($sformatf("cyc_overflow[%0d]", i), 32'(o), 32'(m_ovf[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] w[$], input bit with_last, input bit toggle);
    load_start = 1'b1;
    load_valid = 1'b0;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < w.size(); k++) begin
      if (toggle) begin
        load_valid = 1'b0;
        load_data  = 16'($urandom);
        load_last  = 1'($urandom);
        tick();
      end
      load_valid = 1'b1;
      load_data  = w[k];
      load_last  = with_last && (k == w.size() - 1);
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [14:0] a);
    address = a;
    tick();
  endtask

  initial begin
    logic [15:0] prog7[$];
    logic [15:0] rnd7[$];
    logic [15:0] six[$];
    logic [15:0] next3[$];

    prog7 = {16'h0005, 16'hEC10, 16'h0005, 16'h0005, 16'h0005, 16'h0005, 16'hEC07};
    six   = {16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4, 16'h00A5, 16'h00A6};
    next3 = {16'h1111, 16'h2222, 16'h3333};
    for (int k = 0; k < 7; k++) rnd7.push_back(16'($urandom));

    // Reset behaviour.
    repeat (3) tick();
    chk("rst_data", 32'(data_a), 32'h0);
    chk("rst_ready", 32'(ready_a), 32'h0);
    rst_n = 1'b1;
    cmp_on = 1'b1;
    fetch(15'd0);
    chk("empty_data", 32'(data_a), 32'h0);
    chk("empty_loaded", 32'(loaded_a), 32'h0);
    chk("empty_cpu_rst_n", 32'(crst_a), 32'h0);

    // Seven-word program; the DEPTH 4 instance truncates it.
    do_load(prog7, 1'b1, 1'b0);
    chk("p7_loaded", 32'(loaded_a), 32'h1);
    fetch(15'd1);
    chk("p7_fetch1", 32'(data_a), 32'hEC10);
    fetch(15'd6);
    chk("p7_fetch6", 32'(data_a), 32'hEC07);
    fetch(15'd7);
    chk("p7_fetch7", 32'(data_a), 32'h0);
    chk("p7_ovf_a", 32'(ovf_a), 32'h0);
    chk("p7_ovf_b", 32'(ovf_b), 32'h1);
    fetch(15'd3);
    chk("p7_b_fetch3", 32'(data_b), 32'h0005);

    // Gapped loader stream.
    do_load(rnd7, 1'b1, 1'b1);
    fetch(15'd6);
    chk("gap_fetch6", 32'(data_a), 32'(rnd7[6]));
    fetch(15'd7);
    chk("gap_fetch7", 32'(data_a), 32'h0);
    chk("gap_ovf", 32'(ovf_a), 32'h0);

    // Six words with no last marker.
    do_load(six, 1'b0, 1'b0);
    chk("ovf_b_flag", 32'(ovf_b), 32'h1);
    chk("ovf_b_loaded", 32'(loaded_b), 32'h1);
    chk("nolast_a_loaded", 32'(loaded_a), 32'h0);
    chk("nolast_a_ready", 32'(ready_a), 32'h1);
    fetch(15'd3);
    chk("ovf_b_fetch3", 32'(data_b), 32'h00A4);
    chk("nolast_a_fetch3", 32'(data_a), 32'h0);
    repeat (5) tick();
    chk("nolast_a_still_loading", 32'(loaded_a), 32'h0);

    // Restart while running, with a colliding valid beat.
    do_load(prog7, 1'b1, 1'b0);
    address    = 15'd1;
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'hBEEF;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    chk("restart_loaded", 32'(loaded_a), 32'h0);
    chk("restart_cpu_rst_n", 32'(crst_a), 32'h0);
    chk("restart_data", 32'(data_a), 32'h0);
    repeat (3) tick();
    chk("restart_data_hold", 32'(data_a), 32'h0);
    do_load(next3, 1'b1, 1'b0);
    fetch(15'd0);
    chk("reload_fetch0", 32'(data_a), 32'h1111);
    fetch(15'd2);
    chk("reload_fetch2", 32'(data_a), 32'h3333);

    // Reset during a load.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      load_valid = 1'b1;
      load_data  = 16'h7000 + 16'(k);
      tick();
    end
    load_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midrst_loaded", 32'(loaded_a), 32'h0);
    chk("midrst_data", 32'(data_a), 32'h0);
    tick();
    rst_n = 1'b1;
    fetch(15'd0);
    chk("postrst_data", 32'(data_a), 32'h0);
    chk("postrst_loaded", 32'(loaded_a), 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      load_start = ($urandom_range(0, 29) == 0);
      load_valid = 1'($urandom);
      load_last  = ($urandom_range(0, 9) == 0);
      load_data  = 16'($urandom);
      address    = ($urandom_range(0, 7) == 0) ? 15'($urandom) : 15'($urandom_range(0, 12));
      if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end
    load_start = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    tick();
    cmp_on = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
